// File: rtl/fm_tune_ctrl.sv
// fm_tune_ctrl: retune sequencer in front of fmgen (clk_pcm domain).
// Drives the carrier frequency and gain-scaled audio from a preset channel
// table. A retune ramps the gain down to zero, then slews the carrier in
// bounded steps, then ramps the gain back up. The carrier therefore never
// moves while audio is audible. Retunes come from a manual valid/ready
// request or from an auto-scan dwell timer.
module fm_tune_ctrl #(
  parameter int NCH         = 8,
  parameter int STEP_HZ     = 1000,
  parameter int TICK_DIV    = 48,
  parameter int DWELL_TICKS = 480000,
  parameter int RESET_HZ    = 107900000,
  localparam int AW         = $clog2(NCH)
) (
  input  logic          clk_pcm,
  input  logic          rst,
  input  logic [15:0]   pcm_in,
  output logic [15:0]   pcm_out,
  output logic [31:0]   cw_freq,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_freq,
  input  logic          req_valid,
  input  logic [AW-1:0] req_ch,
  output logic          req_ready,
  input  logic          scan_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] cur_ch
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;

  localparam logic [AW:0]   NCH_LIM    = (AW + 1)'(NCH);
  localparam logic [AW-1:0] CH_LAST    = AW'(NCH - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS);
  localparam logic [31:0]   STEP_32    = 32'(STEP_HZ);
  localparam logic [32:0]   STEP_MAG   = 33'(STEP_HZ);
  localparam logic [31:0]   RESET_32   = 32'(RESET_HZ);
  localparam logic [4:0]    GAIN_FULL  = 5'd16;

  typedef enum logic [1:0] {
    ON_AIR  = 2'd0,
    MUTE_DN = 2'd1,
    SLEW    = 2'd2,
    MUTE_UP = 2'd3
  } state_t;

  state_t                state;
  logic [4:0]            gain;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [DW-1:0]         dwell;
  logic [31:0]           preset [NCH];
  logic [31:0]           target;
  logic [AW-1:0]         target_ch;

  logic signed [21:0]    prod;
  logic signed [32:0]    diff;
  logic [32:0]           dmag;
  logic [31:0]           slew_next;
  logic                  slew_last;

  logic                  accept;
  logic                  req_ok;
  logic                  scan_hit;
  logic [AW-1:0]         next_ch;

  // ---------------------------------------------------------------------
  // Audio path: gain is 0..16 in 1/16 steps. Sign-extend the sample and
  // zero-extend the gain so the product is a true signed multiply, then
  // arithmetic-shift by 4. At gain 16 the result is the input bit-exact,
  // so no saturation is required.
  // ---------------------------------------------------------------------
  assign prod    = $signed({{6{pcm_in[15]}}, pcm_in}) * $signed({17'd0, gain});
  assign pcm_out = 16'(prod >>> 4);

  // ---------------------------------------------------------------------
  // Request decode. req_ready is high exactly in ON_AIR, so accept also
  // implies the FSM is idle. Channel indices at or above NCH are rejected.
  // ---------------------------------------------------------------------
  assign accept   = req_valid & req_ready;
  assign req_ok   = ({1'b0, req_ch} < NCH_LIM);
  assign scan_hit = scan_en && (dwell == DWELL_LAST);
  assign next_ch  = (cur_ch == CH_LAST) ? '0 : cur_ch + AW'(1);
  assign tick     = (presc == PRESC_LAST);

  // Free-running tick prescaler, 0..TICK_DIV-1.
  // NOTE: clocked state is always written with <= so that every flop in the
  // design samples the pre-edge value of every other flop.
  always_ff @(posedge clk_pcm or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Preset table write port; a write lands on the next edge, so a request
  // reading the same index in the same cycle still sees the old value.
  // NOTE: the table has an async reset back to RESET_HZ, which makes it a
  // bank of flops rather than a RAM; a RAM macro could not be cleared here.
  always_ff @(posedge clk_pcm or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        preset[i] <= RESET_32;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < NCH_LIM)) begin
      preset[cfg_addr] <= cfg_freq;
    end
  end

  // Slew step: signed distance to target, widened by one bit so the
  // subtraction cannot overflow. If the remaining distance fits in one
  // step, land exactly on the target, which rules out overshoot.
  // NOTE: every variable gets a value on every path through this block, so
  // no latch can be inferred.
  always_comb begin
    diff      = $signed({target[31], target}) - $signed({cw_freq[31], cw_freq});
    dmag      = diff[32] ? 33'(-diff) : 33'(diff);
    slew_last = (dmag <= STEP_MAG);
    slew_next = diff[32] ? (cw_freq - STEP_32) : (cw_freq + STEP_32);
    if (slew_last) begin
      slew_next = target;
    end
  end

  // Retune FSM with registered status outputs. Ramp and slew actions only
  // advance on tick cycles; request acceptance and scan expiry are checked
  // every cycle while on air.
  always_ff @(posedge clk_pcm or posedge rst) begin
    if (rst) begin
      state     <= ON_AIR;
      gain      <= GAIN_FULL;
      cw_freq   <= RESET_32;
      target    <= RESET_32;
      target_ch <= '0;
      cur_ch    <= '0;
      dwell     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ON_AIR: begin
          if (accept) begin
            // A manual request always wins over a coincident scan expiry.
            dwell <= '0;
            if (req_ok) begin
              target    <= preset[req_ch];
              target_ch <= req_ch;
              state     <= MUTE_DN;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end else if (!scan_en) begin
            dwell <= '0;
          end else if (scan_hit) begin
            dwell     <= '0;
            target    <= preset[next_ch];
            target_ch <= next_ch;
            state     <= MUTE_DN;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else if (tick) begin
            dwell <= dwell + DW'(1);
          end
        end

        MUTE_DN: begin
          if (tick) begin
            gain <= gain - 5'd1;
            if (gain == 5'd1) begin
              state <= SLEW;
            end
          end
        end

        SLEW: begin
          if (tick) begin
            cw_freq <= slew_next;
            if (slew_last) begin
              state <= MUTE_UP;
            end
          end
        end

        MUTE_UP: begin
          if (tick) begin
            gain <= gain + 5'd1;
            if (gain == 5'd15) begin
              state     <= ON_AIR;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              done      <= 1'b1;
              cur_ch    <= target_ch;
            end
          end
        end

        default: begin
          state <= ON_AIR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Bench for fm_tune_ctrl: a table of ON_AIR audio vectors, a table of
// retune requests, and hand-written sequences for scan expiry, request
// collisions, held requests and reset during a slew. Expected retune
// results go into a scoreboard queue when a request is driven and are
// compared when the DUT pulses done or err.
module tb_fm_tune_ctrl;

  localparam int NCH         = 6;
  localparam int STEP_HZ     = 1000;
  localparam int TICK_DIV    = 4;
  localparam int DWELL_TICKS = 3;
  localparam int RESET_HZ    = 107900000;

  logic        clk_pcm;
  logic        rst;
  logic [15:0] pcm_in;
  logic [15:0] pcm_out;
  logic [31:0] cw_freq;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_freq;
  logic        req_valid;
  logic [2:0]  req_ch;
  logic        req_ready;
  logic        scan_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  cur_ch;

  fm_tune_ctrl #(
    .NCH(NCH), .STEP_HZ(STEP_HZ), .TICK_DIV(TICK_DIV),
    .DWELL_TICKS(DWELL_TICKS), .RESET_HZ(RESET_HZ)
  ) dut (
    .clk_pcm(clk_pcm), .rst(rst), .pcm_in(pcm_in), .pcm_out(pcm_out),
    .cw_freq(cw_freq), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_freq(cfg_freq), .req_valid(req_valid), .req_ch(req_ch),
    .req_ready(req_ready), .scan_en(scan_en), .busy(busy), .done(done),
    .err(err), .cur_ch(cur_ch)
  );

  initial clk_pcm = 1'b0;
  always #5 clk_pcm = ~clk_pcm;

  // Cycle count since reset; the DUT prescaler ticks on edges where this
  // becomes a multiple of TICK_DIV.
  int cyc;
  always @(posedge clk_pcm or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic        is_err;
    logic [31:0] cw;
    logic [2:0]  ch;
  } exp_t;

  typedef struct {
    logic [15:0] pin;
    logic [15:0] pout;
  } pvec_t;

  typedef struct {
    logic [2:0]  ch;
    logic        is_err;
    logic [31:0] cw;
    logic [2:0]  exp_ch;
    int          chg;
    int          ticks;
  } vec_t;

  exp_t  sb[$];
  pvec_t ptab[5];
  vec_t  vtab[5];

  int n_vec = 0;
  int n_err = 0;

  int   downs, ups, badg, cw_chg, cw_bad, done_cnt, err_cnt, zero_len;
  logic saw_half;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic is_err);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: err=%0b with empty scoreboard at %0t", is_err, $time);
    end else begin
      e = sb.pop_front();
      check("event_is_err", is_err, e.is_err);
      check("event_cw_freq", cw_freq, e.cw);
      check("event_cur_ch", cur_ch, e.ch);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [31:0] cw, input logic [2:0] ch);
    exp_t e;
    e.is_err = is_err;
    e.cw     = cw;
    e.ch     = ch;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic [2:0] ch);
    req_valid = 1'b1;
    req_ch    = ch;
    @(negedge clk_pcm);
    req_valid = 1'b0;
  endtask

  task automatic write_preset(input logic [2:0] addr, input logic [31:0] f);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_freq = f;
    @(negedge clk_pcm);
    cfg_we = 1'b0;
  endtask

  // Observe the DUT at each falling edge until n_ev done/err events were
  // seen (or the budget expires), gathering ramp and slew statistics.
  // Assumes pcm_in = 0x4000, so pcm_out = 0x400 * gain.
  task automatic watch(input int n_ev, input int budget, input logic [31:0] tgt);
    logic [15:0] po;
    logic [31:0] pc;
    int          k, zs, events, dstep, d0, d1;
    logic        sh;
    po = pcm_out; pc = cw_freq; k = 0; zs = -1; events = 0; sh = 1'b0;
    downs = 0; ups = 0; badg = 0; cw_chg = 0; cw_bad = 0;
    done_cnt = 0; err_cnt = 0; zero_len = -1; saw_half = 1'b0;
    while (events < n_ev && k < budget) begin
      if (pcm_out != po) begin
        if (pcm_out == po - 16'h0400)      downs++;
        else if (pcm_out == po + 16'h0400) ups++;
        else                               badg++;
        if (pcm_out == 16'h0000) zs = k;
        if (pcm_out == 16'h0400 && po == 16'h0000 && zs >= 0) zero_len = k - zs;
        po = pcm_out;
      end
      if (pcm_out == 16'h2000) saw_half = 1'b1;
      if (!sh && pcm_out == 16'h0400 && downs == 15 && zs < 0) begin
        pcm_in = 16'h8001;
        #1;
        check("arith_shift_gain1", pcm_out, 16'hF800);
        pcm_in = 16'h4000;
        #1;
        sh = 1'b1;
      end
      if (cw_freq != pc) begin
        cw_chg++;
        dstep = int'($signed(cw_freq - pc));
        d0    = int'($signed(tgt - pc));
        d1    = int'($signed(tgt - cw_freq));
        if (dstep > STEP_HZ || dstep < -STEP_HZ) cw_bad++;
        if ((d0 > 0 && d1 < 0) || (d0 < 0 && d1 > 0)) cw_bad++;
        pc = cw_freq;
      end
      if (done) begin done_cnt++; events++; sb_pop(1'b0); end
      if (err)  begin err_cnt++;  events++; sb_pop(1'b1); end
      @(negedge clk_pcm);
      k++;
    end
    check("events_seen", events, n_ev);
    repeat (6) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      @(negedge clk_pcm);
    end
  endtask

  task automatic check_stats(input string tag, input int chg, input int ticks);
    check({tag, "_mute_dn_steps"}, downs, 16);
    check({tag, "_mute_up_steps"}, ups, 16);
    check({tag, "_bad_gain_steps"}, badg, 0);
    check({tag, "_slew_changes"}, cw_chg, chg);
    check({tag, "_slew_bad_steps"}, cw_bad, 0);
    check({tag, "_muted_cycles"}, zero_len, (ticks + 1) * TICK_DIV);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_saw_gain8"}, saw_half, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t, g;

    ptab[0] = '{16'h4000, 16'h4000};
    ptab[1] = '{16'h7FFF, 16'h7FFF};
    ptab[2] = '{16'h8000, 16'h8000};
    ptab[3] = '{16'hFFFF, 16'hFFFF};
    ptab[4] = '{16'h0001, 16'h0001};

    vtab[0] = '{3'd2, 1'b0, 32'd107910000, 3'd2, 10, 10};
    vtab[1] = '{3'd2, 1'b0, 32'd107910000, 3'd2, 0,  1};
    vtab[2] = '{3'd5, 1'b0, 32'd107895500, 3'd5, 15, 15};
    vtab[3] = '{3'd7, 1'b1, 32'd107895500, 3'd5, 0,  0};
    vtab[4] = '{3'd6, 1'b1, 32'd107895500, 3'd5, 0,  0};

    rst = 1'b0; pcm_in = 16'h4000; cfg_we = 1'b0; cfg_addr = '0; cfg_freq = '0;
    req_valid = 1'b0; req_ch = '0; scan_en = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk_pcm);
    rst = 1'b0;
    @(negedge clk_pcm);

    check("reset_cw_freq", cw_freq, RESET_HZ);
    check("reset_pcm_out", pcm_out, 16'h4000);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_cur_ch", cur_ch, 3'd0);

    for (int i = 0; i < 5; i++) begin
      pcm_in = ptab[i].pin;
      #1;
      check("on_air_pcm_out", pcm_out, ptab[i].pout);
      @(negedge clk_pcm);
    end
    pcm_in = 16'h4000;

    write_preset(3'd2, 32'd107910000);
    write_preset(3'd5, 32'd107895500);
    write_preset(3'd1, 32'd107903000);
    write_preset(3'd3, 32'd107920000);

    // Table of manual requests.
    for (int i = 0; i < 5; i++) begin
      push_exp(vtab[i].is_err, vtab[i].cw, vtab[i].exp_ch);
      drive_req(vtab[i].ch);
      watch(1, 600, vtab[i].cw);
      if (!vtab[i].is_err) begin
        check_stats("req", vtab[i].chg, vtab[i].ticks);
      end else begin
        check("bad_ch_err_pulses", err_cnt, 1);
        check("bad_ch_done_pulses", done_cnt, 0);
        check("bad_ch_busy", busy, 1'b0);
        check("bad_ch_req_ready", req_ready, 1'b1);
      end
    end

    // Scan expiry from the last channel wraps to channel 0.
    scan_en = 1'b1;
    push_exp(1'b0, RESET_HZ, 3'd0);
    watch(1, 600, RESET_HZ);
    scan_en = 1'b0;
    check_stats("scan_wrap", 5, 5);

    // Manual request in the exact scan-expiry cycle wins.
    repeat (2) @(negedge clk_pcm);
    scan_en = 1'b1;
    t = 0; g = 0;
    while (t < DWELL_TICKS && g < 100) begin
      @(negedge clk_pcm);
      g++;
      if (cyc % TICK_DIV == 0) t++;
    end
    check("scan_not_started_early", busy, 1'b0);
    push_exp(1'b0, 32'd107920000, 3'd3);
    drive_req(3'd3);
    scan_en = 1'b0;
    watch(1, 600, 32'd107920000);
    check("scan_collide_slew_changes", cw_chg, 20);
    check("scan_collide_done_pulses", done_cnt, 1);

    // Preset write and request to the same index in one cycle: old value.
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_freq = 32'd107930000;
    push_exp(1'b0, RESET_HZ, 3'd4);
    drive_req(3'd4);
    cfg_we = 1'b0;
    watch(1, 600, RESET_HZ);
    check("collide_slew_changes", cw_chg, 20);

    // Write during a retune leaves the target alone; a request held while
    // busy is taken once the FSM is back on air.
    push_exp(1'b0, 32'd107930000, 3'd4);
    drive_req(3'd4);
    repeat (80) @(negedge clk_pcm);
    check("mid_retune_busy", busy, 1'b1);
    check("mid_retune_req_ready", req_ready, 1'b0);
    write_preset(3'd4, 32'd107940000);
    req_valid = 1'b1;
    req_ch    = 3'd2;
    push_exp(1'b0, 32'd107910000, 3'd2);
    watch(1, 600, 32'd107930000);
    req_valid = 1'b0;
    watch(1, 600, 32'd107910000);
    check("held_req_done_pulses", done_cnt, 1);

    // Async reset in the middle of a slew.
    drive_req(3'd4);
    g = 0;
    while (cw_freq == 32'd107910000 && g < 400) begin
      @(negedge clk_pcm);
      g++;
    end
    check("slew_started", (cw_freq != 32'd107910000), 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_cw_freq", cw_freq, RESET_HZ);
    check("rst_mid_pcm_out", pcm_out, 16'h4000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    check("rst_mid_cur_ch", cur_ch, 3'd0);
    @(negedge clk_pcm);
    rst = 1'b0;
    @(negedge clk_pcm);

    // Presets are back at RESET_HZ, so this retune has one flat slew tick.
    push_exp(1'b0, RESET_HZ, 3'd4);
    drive_req(3'd4);
    watch(1, 600, RESET_HZ);
    check_stats("post_rst", 0, 1);

    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fm_tune_ctrl.md
Name: fm_tune_ctrl

Overview:
Retune sequencer that sits in front of fmgen in the clk_pcm domain. It drives fmgen's cw_freq and pcm_in from a preset channel table, and runs a click-free retune: mute ramp down, carrier frequency slew, then mute ramp up. Retunes come from a manual request handshake or from an auto-scan dwell timer.

Parameters:
NCH, 8, number of preset channels (2..256)
STEP_HZ, 1000, max carrier change per slew tick, Hz (>0)
TICK_DIV, 48, clk_pcm cycles per tick (>=2)
DWELL_TICKS, 480000, ticks spent on a channel in scan mode before auto-advance
RESET_HZ, 107900000, reset carrier and reset value of every preset

Ports:
clk_pcm  in  1  PCM-domain clock
rst  in  1  asynchronous reset, active-high
pcm_in  in  16  signed audio from source
pcm_out  out  16  signed gain-scaled audio to fmgen pcm_in
cw_freq  out  32  signed carrier Hz to fmgen cw_freq
cfg_we  in  1  preset write strobe
cfg_addr  in  $clog2(NCH)  preset index
cfg_freq  in  32  preset value, Hz
req_valid  in  1  manual retune request
req_ch  in  $clog2(NCH)  requested channel
req_ready  out  1  request acceptance
scan_en  in  1  enable auto-scan
busy  out  1  retune in progress
done  out  1  one-cycle pulse when a retune completes
err  out  1  one-cycle pulse when a request is rejected
cur_ch  out  $clog2(NCH)  channel currently on air

Behaviour:
- Reset values: cw_freq=RESET_HZ; gain=16; pcm_out=pcm_in (gain applied combinationally); cur_ch=0; all presets=RESET_HZ; state ON_AIR; busy/done/err=0; req_ready=1; prescaler=0; dwell=0.
- Tick: prescaler counts 0..TICK_DIV-1 and wraps, free-running. tick=1 on the cycle the prescaler equals TICK_DIV-1. All ramp and slew actions happen only on tick cycles.
- Gain: 5-bit value, 0..16. pcm_out = (pcm_in * gain) >>> 4, arithmetic shift. Full-scale with gain 16 is exact; no saturation is needed.
- States:
  - ON_AIR: busy=0; req_ready=1.
  - MUTE_DN: gain-=1 per tick. When gain reaches 0, go to SLEW on the same tick.
  - SLEW: per tick, d = target - cw_freq. If |d| <= STEP_HZ, cw_freq=target and go to MUTE_UP. Otherwise cw_freq += sign(d)*STEP_HZ.
  - MUTE_UP: gain+=1 per tick. When gain reaches 16, go to ON_AIR, pulse done, update cur_ch=target channel.
- Accept: req_valid & req_ready. If req_ch < NCH: latch target = preset[req_ch] and the channel index, go to MUTE_DN next cycle. If req_ch >= NCH: pulse err, stay in ON_AIR.
- req_ready=0 in all states except ON_AIR. A request held during busy waits; it is not dropped.
- Scan: the dwell counter increments per tick while in ON_AIR with scan_en=1. It clears on entering ON_AIR and whenever scan_en=0. When it reaches DWELL_TICKS, the block starts a retune to (cur_ch+1) mod NCH, wrapping NCH-1 to 0.
- Manual request and scan expiry in the same cycle: the manual request wins and the dwell counter clears.
- Retune to the current channel or an equal frequency: the full mute down/up sequence still runs, with a single SLEW tick.
- Preset write: takes effect next cycle. It never alters an in-progress target or the on-air cw_freq. Write and request to the same index in the same cycle: the request latches the old value.
- Duration: first tick may be partial. Retune time ≈ (16 + max(1, ceil(|d|/STEP_HZ)) + 16) ticks.
- cw_freq is 32-bit signed. Slew never overshoots the target. No wrap handling is needed for valid FM-band values.
- Async reset asserted mid-retune: immediate return to all reset values, with cw_freq=RESET_HZ and gain=16. Presets also reset.

Test Plan:
- Reset, then hold pcm_in=0x4000 -> cw_freq=107900000, pcm_out=0x4000, req_ready=1, busy=0.
- TICK_DIV=4. Write preset[2]=107910000, then request ch2 -> 16 MUTE_DN ticks, pcm_in=0x4000 at gain 8 gives pcm_out=0x2000, 10 SLEW steps of +1000, cw_freq=107910000, 16 MUTE_UP ticks, done pulses once, cur_ch=2.
- pcm_in=0x8001 with gain 1 -> pcm_out=0xF800, confirming arithmetic shift.
- NCH=6, req_ch=7 -> err pulses one cycle, state unchanged, req_ready stays 1.
- scan_en=1, DWELL_TICKS=3, cur_ch=5 (NCH=6) -> auto-retune to ch0. Assert req_valid ch3 in the expiry cycle -> target is ch3.
- Assert rst mid-SLEW -> next edge shows cw_freq=RESET_HZ, gain=16, busy=0, presets=RESET_HZ.
